// File: rtl/pong_pkg.sv
// Shared Pong definitions: sound cue codes and sequencer FSM states.
package pong_pkg;

    typedef logic [1:0] sfx_cue_t;

    localparam sfx_cue_t CUE_WALL   = 2'b00;
    localparam sfx_cue_t CUE_PADDLE = 2'b01;
    localparam sfx_cue_t CUE_SCORE  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_TRIG = 2'b01,
        S_HOLD = 2'b10,
        S_GAP  = 2'b11
    } sfx_state_t;

endpackage

// File: rtl/sfx_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle (the head is read before the slot is rewritten).
module sfx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CNTW'(1);
            else if (do_pop && !do_push) count <= count - CNTW'(1);
        end
    end

    // Storage write; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pong_sfx_sequencer.sv
// Queues Pong game events as sound cues and replays them as spaced beeper
// triggers with a tone select; score cues beep twice.
module pong_sfx_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned BEEP_CYCLES = 8388608,
    parameter int unsigned GAP_CYCLES  = 2500000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          paddle_hit,
    input  logic                          wall_hit,
    input  logic                          score,
    output logic                          beep_trig,
    output logic [1:0]                    tone_sel,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          dropped
);

    localparam int unsigned CMAX = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX) + 1;

    sfx_state_t state;
    sfx_state_t state_next;
    logic [CW-1:0] cnt;
    sfx_cue_t cue_q;
    logic     rep_q;

    sfx_cue_t ev_cue;
    logic     ev_any;
    logic     ev_multi;
    logic     push;
    logic     pop;
    sfx_cue_t head;
    logic     fifo_full;
    logic     fifo_empty;

    logic       trig_d;
    logic [1:0] tone_d;
    logic       busy_d;
    logic       drop_d;

    // Priority pick of the single cue enqueued this cycle.
    always_comb begin
        ev_cue   = CUE_WALL;
        ev_any   = score | paddle_hit | wall_hit;
        ev_multi = (score & paddle_hit) | (score & wall_hit) | (paddle_hit & wall_hit);
        if (score)           ev_cue = CUE_SCORE;
        else if (paddle_hit) ev_cue = CUE_PADDLE;
    end

    assign push = ev_any && !rst;
    assign pop  = (state == S_IDLE) && !fifo_empty;

    sfx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (ev_cue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (!fifo_empty) state_next = S_TRIG;
            S_TRIG: state_next = S_HOLD;
            S_HOLD: if (cnt == '0) state_next = S_GAP;
            S_GAP: begin
                if (cnt == '0) begin
                    if ((cue_q == CUE_SCORE) && !rep_q) state_next = S_TRIG;
                    else                                state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the upcoming state.
    always_comb begin
        trig_d = (state_next == S_TRIG);
        busy_d = (state_next != S_IDLE);
        tone_d = tone_sel;
        if (state_next == S_TRIG) tone_d = (state == S_IDLE) ? head : cue_q;
        drop_d = ev_multi || (ev_any && fifo_full && !pop);
    end

    // Shared HOLD/GAP down-counter, reloaded on entry, parked at zero.
    always_ff @(posedge clk) begin
        if (rst)                               cnt <= '0;
        else if (state == S_TRIG)              cnt <= CW'(BEEP_CYCLES - 1);
        else if (state == S_HOLD && cnt == '0) cnt <= CW'(GAP_CYCLES - 1);
        else if (cnt != '0)                    cnt <= cnt - CW'(1);
    end

    // Latched cue and score-repeat flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cue_q <= CUE_WALL;
            rep_q <= 1'b0;
        end else if (pop) begin
            cue_q <= head;
            rep_q <= 1'b0;
        end else if (state == S_GAP && state_next == S_TRIG) begin
            rep_q <= 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            beep_trig <= 1'b0;
            tone_sel  <= 2'b00;
            busy      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            beep_trig <= trig_d;
            tone_sel  <= tone_d;
            busy      <= busy_d;
            dropped   <= drop_d;
        end
    end

endmodule

// File: tb/tb_pong_sfx_sequencer.sv
// Randomized bench for pong_sfx_sequencer against a transaction-level model:
// a cue queue plus a schedule of expected trigger/busy/drop cycles.
module tb_pong_sfx_sequencer;

    localparam int B = 8;
    localparam int G = 4;
    localparam int D = 4;
    localparam int P = 1 + B + G;
    localparam int N = 3000;
    localparam int M = N + 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       paddle_hit;
    logic       wall_hit;
    logic       score;
    logic       beep_trig;
    logic [1:0] tone_sel;
    logic       busy;
    logic [2:0] q_count;
    logic       dropped;

    pong_sfx_sequencer #(
        .BEEP_CYCLES (B),
        .GAP_CYCLES  (G),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .paddle_hit (paddle_hit),
        .wall_hit   (wall_hit),
        .score      (score),
        .beep_trig  (beep_trig),
        .tone_sel   (tone_sel),
        .busy       (busy),
        .q_count    (q_count),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp, input int cyc);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Model schedule, indexed by cycle.
    bit e_trig [M];
    int e_tone [M];
    bit e_busy [M];
    bit e_drop [M];
    int e_q    [M];
    bit e_rst  [M];
    int q [$];
    int idle_from = 0;
    int cur_tone  = 0;
    bit valid     = 1'b0;

    initial begin
        int rate;
        int cue;
        int nrep;
        int nev;
        bit drop;
        rst = 1'b1;
        paddle_hit = 1'b0;
        wall_hit = 1'b0;
        score = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            if (c < 1000)      rate = 16;
            else if (c < 2000) rate = 2;
            else               rate = 6;
            rst        = (c < 2) || ($urandom_range(0, 299) == 0);
            paddle_hit = ($urandom_range(0, rate - 1) == 0);
            wall_hit   = ($urandom_range(0, rate - 1) == 0);
            score      = ($urandom_range(0, rate + 2) == 0);

            @(negedge clk);
            if (valid) begin
                if (e_rst[c])  cur_tone = 0;
                if (e_trig[c]) cur_tone = e_tone[c];
                chk("beep_trig", 8'(beep_trig), 8'(e_trig[c]), c);
                chk("tone_sel",  8'(tone_sel),  8'(cur_tone),  c);
                chk("busy",      8'(busy),      8'(e_busy[c]), c);
                chk("q_count",   8'(q_count),   8'(e_q[c]),    c);
                chk("dropped",   8'(dropped),   8'(e_drop[c]), c);
            end

            if (rst) begin
                q.delete();
                idle_from = c + 1;
                for (int k = c + 1; k < M; k++) begin
                    e_trig[k] = 1'b0;
                    e_busy[k] = 1'b0;
                    e_drop[k] = 1'b0;
                end
                e_q[c+1]   = 0;
                e_rst[c+1] = 1'b1;
                valid      = 1'b1;
            end else begin
                // Sequencer side: an idle sequencer takes the head cue.
                if (c >= idle_from && q.size() > 0) begin
                    cue  = q.pop_front();
                    nrep = (cue == 2) ? 2 : 1;
                    for (int i = 0; i < nrep; i++) begin
                        e_trig[c+1+i*P] = 1'b1;
                        e_tone[c+1+i*P] = cue;
                    end
                    for (int k = c + 1; k <= c + nrep * P; k++) e_busy[k] = 1'b1;
                    idle_from = c + 1 + nrep * P;
                end
                // Event side: one cue per cycle, extras and overflow dropped.
                nev  = int'(score) + int'(paddle_hit) + int'(wall_hit);
                drop = (nev > 1);
                if (nev > 0) begin
                    cue = score ? 2 : (paddle_hit ? 1 : 0);
                    if (q.size() < D) q.push_back(cue);
                    else              drop = 1'b1;
                end
                e_drop[c+1] = drop;
                e_q[c+1]    = q.size();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
